// File: rtl/prog_loader.sv
// Program memory and byte-serial loader feeding the 8-bit CPU; optional checksum via LOADER_CHECKSUM_EN.
// Latency: one byte written per cycle; asynchronous zero-latency instruction read.
// Backpressure: ld_ready is high only in LEN/DATA(/CHK); load_start aborts and discards a concurrent byte.
module prog_loader #(
   parameter int              AW          = 8,
   parameter int              DW          = 8,
   parameter logic [DW-1:0]   STALL_INSTR = '0
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load_start,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   input  logic [AW-1:0] address,
   output logic [DW-1:0] instruction,
   output logic          cpu_run,
   output logic          load_done,
   output logic          load_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
      S_ERR,
`endif
      S_RUN
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] ptr;
   logic [AW-1:0] len_q;
   logic          accept;
   logic          last_byte;
   logic          wr_en;
   logic [DW-1:0] mem [2**AW];
`ifdef LOADER_CHECKSUM_EN
   logic [DW-1:0] sum;
   logic [DW-1:0] chk_total;

   assign chk_total = sum + ld_data;
`endif

   assign accept    = ld_valid && ld_ready;
   // len_q of 0 means 2**AW bytes: the last byte then lands at ptr = 2**AW-1
   assign last_byte = (ptr == len_q - AW'(1));
   assign wr_en     = accept && !load_start && (state == S_DATA);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (load_start) state_nxt = S_LEN;
         S_LEN:  if (accept) state_nxt = S_DATA;
`ifdef LOADER_CHECKSUM_EN
         S_DATA: if (accept && last_byte) state_nxt = S_CHK;
         S_CHK:  if (accept) state_nxt = (chk_total == '0) ? S_RUN : S_ERR;
         S_ERR:  state_nxt = S_ERR;
`else
         S_DATA: if (accept && last_byte) state_nxt = S_RUN;
`endif
         S_RUN:  state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
      if (load_start) state_nxt = S_LEN;
   end

   always_comb begin
      ld_ready = 1'b0;
      cpu_run  = 1'b0;
      load_err = 1'b0;
      case (state)
         S_LEN, S_DATA: ld_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         S_CHK:  ld_ready = 1'b1;
         S_ERR:  load_err = 1'b1;
`endif
         S_RUN:  cpu_run  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         len_q     <= '0;
         load_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum       <= '0;
`endif
      end else begin
         load_done <= (state_nxt == S_RUN) && (state != S_RUN);
         if (accept && !load_start) begin
            if (state == S_LEN) begin
               len_q <= ld_data[AW-1:0];
               ptr   <= '0;
`ifdef LOADER_CHECKSUM_EN
               sum   <= '0;
`endif
            end else if (state == S_DATA) begin
               ptr   <= ptr + 1'b1;
`ifdef LOADER_CHECKSUM_EN
               sum   <= sum + ld_data;
`endif
            end
         end
      end
   end

   // Program memory is deliberately not reset so an aborted load keeps prior contents
   always_ff @(posedge clock) begin
      if (wr_en) mem[ptr] <= ld_data;
   end

   assign instruction = cpu_run ? mem[address] : STALL_INSTR;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a byte-level model of memory contents and load outcome.
module tb_prog_loader;
   localparam logic [7:0] STALL = 8'h00;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       load_start = 1'b0;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_data = 8'h00;
   logic [7:0] address = 8'h00;
   logic       ld_ready;
   logic [7:0] instruction;
   logic       cpu_run;
   logic       load_done;
   logic       load_err;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_mem [256];
   bit         known [256];
   logic [7:0] pay_q [$];
   int         c2, c3, c4, cx;

   prog_loader #(.AW(8), .DW(8), .STALL_INSTR(8'h00)) dut (
      .clock(clock), .reset(reset), .load_start(load_start),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .address(address), .instruction(instruction), .cpu_run(cpu_run),
      .load_done(load_done), .load_err(load_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_mem();
      for (int a = 0; a < 256; a++) begin
         if (known[a]) begin
            address = a[7:0];
            #1;
            check("mem_rd", instruction, model_mem[a]);
         end
      end
      @(negedge clock);
   endtask

   // chk_mode: 0 none, 1 good checksum appended, 2 bad checksum appended
   task automatic do_load(input logic [7:0] len_b, input int mode, input int chk_mode, output int cycles);
      logic [7:0] s_q [$];
      logic [7:0] sum;
      int         n, idx;
      bit         v, exp_err;
      n   = (len_b == 8'h00) ? 256 : int'(len_b);
      sum = 8'h00;
      s_q = {};
      s_q.push_back(len_b);
      for (int i = 0; i < n; i++) begin
         s_q.push_back(pay_q[i]);
         sum = sum + pay_q[i];
      end
      exp_err = (chk_mode == 2);
      if (chk_mode == 1) s_q.push_back(8'h00 - sum);
      if (chk_mode == 2) s_q.push_back(8'h01 - sum);
      @(negedge clock);
      load_start = 1'b1;
      ld_valid   = 1'b0;
      @(negedge clock);
      load_start = 1'b0;
      idx    = 0;
      cycles = 0;
      while (idx < s_q.size() && cycles < 2000) begin
         check("ld_ready_load", ld_ready, 1);
         check("stall_load", instruction, STALL);
         check("run_low_load", cpu_run, 0);
         address = 8'($urandom);
         case (mode)
            0:       v = 1'b1;
            1:       v = cycles[0];
            default: v = 1'($urandom_range(0, 1));
         endcase
         ld_valid = v;
         ld_data  = v ? s_q[idx] : 8'($urandom);
         if (v && ld_ready) begin
            if (idx >= 1 && idx <= n) begin
               model_mem[(idx - 1) % 256] = s_q[idx];
               known[(idx - 1) % 256]     = 1'b1;
            end
            idx++;
         end
         @(negedge clock);
         cycles++;
      end
      ld_valid = 1'b0;
      check("load_complete", idx, s_q.size());
      if (exp_err) begin
         check("err_flag", load_err, 1);
         check("err_run", cpu_run, 0);
         check("err_ready", ld_ready, 0);
         check("err_done", load_done, 0);
      end else begin
         check("done_pulse", load_done, 1);
         check("run_high", cpu_run, 1);
         check("run_ready", ld_ready, 0);
         check("run_err", load_err, 0);
         @(negedge clock);
         check("done_once", load_done, 0);
         check("run_hold", cpu_run, 1);
      end
   endtask

   initial begin
      #2 reset = 1'b0;
      #1;
      check("rst_ready", ld_ready, 0);
      check("rst_run", cpu_run, 0);
      check("rst_done", load_done, 0);
      check("rst_err", load_err, 0);
      check("rst_instr", instruction, STALL);
      #20;
      @(negedge clock) reset = 1'b1;

      // IDLE ignores bytes
      ld_valid = 1'b1;
      ld_data  = 8'h33;
      repeat (3) begin
         @(negedge clock);
         check("idle_ready", ld_ready, 0);
         check("idle_run", cpu_run, 0);
      end
      ld_valid = 1'b0;

      // Reset in the middle of DATA after 3 of 5 bytes
      @(negedge clock) load_start = 1'b1;
      @(negedge clock) load_start = 1'b0;
      ld_valid = 1'b1;
      ld_data  = 8'd5;
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         ld_data      = 8'($urandom);
         model_mem[i] = ld_data;
         known[i]     = 1'b1;
         @(negedge clock);
      end
      ld_valid = 1'b0;
      check("mid_ready", ld_ready, 1);
      reset = 1'b0;
      #1;
      check("mid_rst_ready", ld_ready, 0);
      check("mid_rst_run", cpu_run, 0);
      check("mid_rst_done", load_done, 0);
      check("mid_rst_err", load_err, 0);
      check("mid_rst_instr", instruction, STALL);
      @(negedge clock) reset = 1'b1;

      // Basic load, valid held high
      pay_q = '{8'h41, 8'h82, 8'hC3};
      do_load(8'h03, 0, 0, c2);
      check("t2_cycles", c2, 4);
      address = 8'd0; #1 check("t2_a0", instruction, 8'h41);
      address = 8'd1; #1 check("t2_a1", instruction, 8'h82);
      address = 8'd2; #1 check("t2_a2", instruction, 8'hC3);
      check_mem();

      // Same stream with valid toggling
      do_load(8'h03, 1, 0, c3);
      check("t3_delay", c3, c2 + 4);
      check_mem();

      // Full-depth load with length byte 0
      pay_q = {};
      for (int i = 0; i < 256; i++) pay_q.push_back(8'(i) ^ 8'h5A);
      do_load(8'h00, 0, 0, c4);
      check("t4_cycles", c4, 257);
      address = 8'hFF; #1 check("t4_a255", instruction, 8'hA5);
      check_mem();

      // Abort from RUN, then a 1-byte reload keeps the rest
      @(negedge clock) load_start = 1'b1;
      @(negedge clock) load_start = 1'b0;
      address = 8'h00;
      #1;
      check("t5_run_drop", cpu_run, 0);
      check("t5_stall", instruction, STALL);
      check("t5_ready", ld_ready, 1);
      pay_q = '{8'h7E};
      do_load(8'h01, 0, 0, cx);
      address = 8'd1; #1 check("t5_a1_kept", instruction, 8'h5B);
      check_mem();

      // Bytes offered in RUN are ignored
      ld_valid = 1'b1;
      ld_data  = 8'hFF;
      repeat (3) begin
         @(negedge clock);
         check("run_ignore_ready", ld_ready, 0);
         check("run_ignore_run", cpu_run, 1);
      end
      ld_valid = 1'b0;
      check_mem();

      // load_start beats a concurrent byte accept
      @(negedge clock) load_start = 1'b1;
      @(negedge clock) load_start = 1'b0;
      ld_valid = 1'b1;
      ld_data  = 8'd4;
      @(negedge clock);
      ld_data = 8'h11; model_mem[0] = 8'h11;
      @(negedge clock);
      ld_data = 8'h22; model_mem[1] = 8'h22;
      @(negedge clock);
      load_start = 1'b1;
      ld_data    = 8'hEE;
      @(negedge clock);
      load_start = 1'b0;
      ld_valid   = 1'b0;
      check("prio_ready", ld_ready, 1);
      check("prio_run", cpu_run, 0);
      pay_q = '{8'h99};
      do_load(8'h01, 2, 0, cx);
      check_mem();

      // Randomized loads
      repeat (5) begin
         int n;
         n = $urandom_range(1, 40);
         pay_q = {};
         for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
         do_load(8'(n), 2, 0, cx);
         check_mem();
      end

`ifdef LOADER_CHECKSUM_EN
      pay_q = '{8'h10, 8'h20};
      do_load(8'h02, 2, 1, cx);
      check_mem();
      do_load(8'h02, 0, 2, cx);
      repeat (3) begin
         @(negedge clock);
         check("err_hold", load_err, 1);
         check("err_hold_run", cpu_run, 0);
         check("err_hold_instr", instruction, STALL);
      end
      @(negedge clock) load_start = 1'b1;
      @(negedge clock) load_start = 1'b0;
      check("err_clear", load_err, 0);
      check("err_clear_ready", ld_ready, 1);
      pay_q = {};
      for (int i = 0; i < 7; i++) pay_q.push_back(8'($urandom));
      do_load(8'h07, 2, 1, cx);
      check_mem();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
